// File: rtl/load_store_unit.sv
// Load/store unit: validates a CPU memory access, issues one word-aligned
// valid/ready bus request, formats store lanes and sign/zero-extends loads.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  memory_control,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output logic [1:0]  fault_code,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_CONTROL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // memory_control = {u, h, b, w}; invalid control outranks misalignment
  function automatic logic [1:0] decode_fault(input logic [3:0] mc, input logic [1:0] a);
    logic u, h, b, w;
    logic [1:0] res;
    {u, h, b, w} = mc;
    if ((h & b) | (u & w) | (u & ~h & ~b)) begin
      res = FAULT_CONTROL;
    end else if ((h & a[0]) | (~h & ~b & (a != 2'b00))) begin
      res = FAULT_MISALIGN;
    end else begin
      res = FAULT_OK;
    end
    return res;
  endfunction

  function automatic logic [3:0] lane_mask(input logic h, input logic b, input logic [1:0] a);
    logic [3:0] res;
    case ({h, b})
      2'b01:   res = 4'b0001 << a;
      2'b10:   res = 4'b0011 << {a[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_data(input logic h, input logic b, input logic [31:0] wd);
    logic [31:0] res;
    case ({h, b})
      2'b01:   res = {4{wd[7:0]}};
      2'b10:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] uhb, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res;
    case (a)
      2'd0:    byte_s = rd[7:0];
      2'd1:    byte_s = rd[15:8];
      2'd2:    byte_s = rd[23:16];
      default: byte_s = rd[31:24];
    endcase
    half_s = a[1] ? rd[31:16] : rd[15:0];
    case (uhb[1:0])
      2'b01:   res = {{24{~uhb[2] & byte_s[7]}}, byte_s};
      2'b10:   res = {{16{~uhb[2] & half_s[15]}}, half_s};
      default: res = rd;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic [1:0]  fault_q, fault_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  fault_s;

  // Next-state and datapath capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    lane_d      = lane_q;
    fault_s     = decode_fault(memory_control, address[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          read_data_d = 32'd0;
          fault_d     = fault_s;
          cnt_d       = 8'd0;
          if (fault_s != FAULT_OK) begin
            state_d = ST_COMPLETE;
          end else begin
            state_d     = ST_REQUEST;
            bus_write_d = memory_control[0];
            bus_addr_d  = {address[31:2], 2'b00};
            be_d        = lane_mask(memory_control[2], memory_control[1], address[1:0]);
            wdata_d     = memory_control[0] ?
                          store_data(memory_control[2], memory_control[1], write_data) : 32'd0;
            ctrl_d      = memory_control[3:1];
            lane_d      = address[1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        // A handshake in the same cycle as the timeout still completes cleanly
        if (bus_ready) begin
          if (!bus_write_q) begin
            read_data_d = load_extract(ctrl_q, lane_q, bus_read_data);
          end else begin
            read_data_d = read_data_q;
          end
          fault_d = FAULT_OK;
          state_d = ST_COMPLETE;
        end else if ((cnt_q + 8'd1) == TIMEOUT_LIMIT) begin
          cnt_d   = cnt_q + 8'd1;
          fault_d = FAULT_TIMEOUT;
          state_d = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      read_data_q <= 32'd0;
      fault_q     <= 2'b00;
      bus_write_q <= 1'b0;
      bus_addr_q  <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      ctrl_q      <= 3'd0;
      lane_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      lane_q      <= lane_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_COMPLETE);
  assign bus_valid       = (state_q == ST_REQUEST);
  assign read_data       = read_data_q;
  assign fault_code      = fault_q;
  assign bus_write       = bus_write_q;
  assign bus_address     = bus_addr_q;
  assign bus_byte_enable = be_q;
  assign bus_write_data  = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side endpoint for the main decoder's `memory_control` field (bits: u, h, b, r/w).
- On `start`, the block:
  - validates the access;
  - issues a single word-aligned request on a valid/ready data bus;
  - formats store byte lanes, or extracts and sign/zero-extends load data;
  - reports completion or fault to the CPU stall/writeback logic.
- Sits between the CPU datapath and data memory / bus fabric.

Parameters:
- `TIMEOUT_CYCLES`, default 255: bus cycles `bus_valid` may wait for `bus_ready` before a timeout fault. Range 1..255.

Ports:
- `clock` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin access; sampled only in IDLE.
- `memory_control` input 4: {u, h, b, w}; w=1 store, w=0 load; h=b=0 word.
- `address` input 32: byte address.
- `write_data` input 32: store data; low byte/half used for sb/sh.
- `busy` output 1: access in progress; CPU stalls.
- `done` output 1: one-cycle completion pulse.
- `read_data` output 32: formatted load result; valid when `done` and `fault_code`=00.
- `fault_code` output 2: 00 ok, 01 misaligned, 10 invalid control, 11 timeout; valid with `done`.
- `bus_valid` output 1: request valid.
- `bus_ready` input 1: request accepted/completed this cycle.
- `bus_write` output 1: 1 store, 0 load.
- `bus_address` output 32: {address[31:2], 2'b00}.
- `bus_byte_enable` output 4: active lanes.
- `bus_write_data` output 32: lane-replicated store data.
- `bus_read_data` input 32: load data; valid when `bus_valid & bus_ready & ~bus_write`.

Behaviour:
- **Reset.** Asynchronous on `reset_n`=0, including mid-transfer; no partial completion is reported. All of these reset to 0 and state to IDLE: `busy`, `done`, `read_data`, `fault_code`, `bus_valid`, `bus_write`, `bus_address`, `bus_byte_enable`, `bus_write_data`, timeout counter.
- **States.** IDLE, REQUEST, COMPLETE.
- **IDLE.**
  - `start`=1 with a legal, aligned access: register all bus outputs, go to REQUEST.
  - `start`=1 with an illegal access: register `fault_code`, go to COMPLETE; no bus request is issued.
  - `start`=0: stay in IDLE.
- **Illegal accesses.**
  - Invalid control: h&b=1; u&w=1; u with word width.
  - Misaligned: half with address[0]=1; word with address[1:0]≠0.
  - Invalid control takes priority over misaligned.
- **REQUEST.**
  - `bus_valid`=1. `bus_address`, `bus_write`, `bus_byte_enable`, `bus_write_data` are held stable until the handshake.
  - Timeout counter increments each cycle `bus_ready`=0.
  - On `bus_ready`=1: capture the formatted load data (loads only), go to COMPLETE with `fault_code`=00.
  - If the counter reaches `TIMEOUT_CYCLES` without `bus_ready`: `fault_code`=11, go to COMPLETE.
  - `bus_ready` and timeout in the same cycle: `bus_ready` wins.
- **COMPLETE.** `done`=1 for exactly one cycle; `bus_valid`=0; return to IDLE. `read_data` and `fault_code` hold until the next `start` is accepted.
- **busy / start.**
  - `busy` = (state ≠ IDLE).
  - `start` while busy is ignored.
  - A new `start` is accepted in the cycle after COMPLETE.
- **Latency.** `start` at cycle 0 → `bus_valid` at cycle 1 → with `bus_ready` at cycle 1, `done` at cycle 2. A fault-on-decode gives `done` at cycle 1.
- **Store formatting.**
  - Byte: data = {4{wd[7:0]}}, enable = 4'b0001 << address[1:0].
  - Half: data = {2{wd[15:0]}}, enable = 4'b0011 << (2*address[1]).
  - Word: data = wd, enable = 4'b1111.
- **Load formatting.**
  - Byte lane: address[1:0] selects the byte; sign-extend bit 7 unless u, then zero-extend.
  - Half lane: address[1] selects the half; extend from bit 15 likewise.
  - Word: pass through.
  - Loads drive `bus_byte_enable` with the same lane mask as stores.
  - `bus_write_data`=0 on loads.

Test Plan:
- **sw.** `memory_control`=0001, address=0x100, data=0xDEADBEEF, `bus_ready` at cycle 1.
  → `bus_address`=0x100, enable=1111, write=1, `done` at cycle 2, `fault_code`=00.
- **lb/lbu.** `bus_read_data`=0x80FF7F01.
  - lb at address 0x203 (0010) → `read_data`=0xFFFFFF80.
  - lbu at 0x203 (1010) → 0x00000080.
  - lb at 0x201 → 0x0000007F.
  - All four lanes cover enable 0001..1000.
- **sh/lh.** sh at 0x302 with data 0x1234ABCD → enable=1100, `bus_write_data`=0xABCDABCD. lh at 0x302 with read 0x8001xxxx → 0xFFFF8001.
- **Faults.**
  - lw at 0x101 → no `bus_valid`, `done` at cycle 1, `fault_code`=01.
  - `memory_control`=1111 → `fault_code`=10 (priority over misalign).
- **Timeout and stall.** `TIMEOUT_CYCLES`=4, `bus_ready` held 0 → `bus_valid` high 4 cycles, then `fault_code`=11 and `done`. `bus_ready` after 3 waits → ok. `start` pulsed while busy → ignored.
- **Reset mid-REQUEST.** Deassert `reset_n` while `bus_valid`=1 → `bus_valid`, `busy`, `done` go 0 immediately (asynchronous); after release, a fresh lw completes normally.
